sine_phase_sequencer: RTL and testbench

Two-channel phase-accumulator controller that sequences the dual-channel sine LUT datapath. It generates PHASE_A and PHASE_B and a one-cycle sample strobe for the sine block's sample enable. Each channel supports continuous or N-cycle burst playback with start and stop control. It sits between the register/command interface and the sine lookup stage.

---
 rtl/sine_phase_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sine_phase_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_sequencer.sv
// sine_phase_sequencer
// ---------------------------------------------------------------------------
// Two-channel phase-accumulator controller for the dual-channel sine LUT.
// A shared sample-rate divider produces a one-cycle SAMPLE_STB. On each
// strobe a running channel adds its frequency tuning word to a 32-bit
// accumulator and publishes PHASE_x = acc + OFS_x (mod 2^32). A channel runs
// continuously (CYCLES_x == 0) or for CYCLES_x full waveform cycles, where a
// waveform cycle completes whenever the accumulator addition carries out.
//
// Command interface: START_x / STOP_x are single-cycle pulses with no
// handshake; they are acted on at the rising edge in which they are high.
// STOP beats START when both arrive together.
//
// Optional build macro: SINE_SEQ_SYNC_AB_EN
//   defined   - START_A / STOP_A drive both channels, START_B / STOP_B are
//               ignored, so both accumulators restart on the same edge.
//   undefined - the two channels are fully independent.
//
// Ports
//   CLK, RESET_N          clock (rising edge), async active-low reset
//   SAMPLE_DIV            strobe every SAMPLE_DIV+1 clocks
//   START_x, STOP_x       per-channel start/restart and stop pulses
//   FTW_x, OFS_x          tuning word and phase offset, used live
//   CYCLES_x              burst length, latched at START (0 = continuous)
//   SAMPLE_STB            sample strobe for the sine stage
//   PHASE_x               registered phase word
//   ACTIVE_x, DONE_x      channel running / sticky burst-complete
//   DBG_STATE_x           channel FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module sine_phase_sequencer #(
  parameter int DIV_WIDTH = 16,
  parameter int CYC_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [DIV_WIDTH-1:0] SAMPLE_DIV,
  input  logic                 START_A,
  input  logic                 START_B,
  input  logic                 STOP_A,
  input  logic                 STOP_B,
  input  logic [31:0]          FTW_A,
  input  logic [31:0]          FTW_B,
  input  logic [31:0]          OFS_A,
  input  logic [31:0]          OFS_B,
  input  logic [CYC_WIDTH-1:0] CYCLES_A,
  input  logic [CYC_WIDTH-1:0] CYCLES_B,
  output logic                 SAMPLE_STB,
  output logic [31:0]          PHASE_A,
  output logic [31:0]          PHASE_B,
  output logic                 ACTIVE_A,
  output logic                 ACTIVE_B,
  output logic                 DONE_A,
  output logic                 DONE_B,
  output logic [1:0]           DBG_STATE_A,
  output logic [1:0]           DBG_STATE_B
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CYC_WIDTH-1:0] CYC_ONE = {{(CYC_WIDTH-1){1'b0}}, 1'b1};

  // ---------------- shared divider ----------------
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 armed_q, armed_d;
  logic                 div_hit;

  // The counter wraps only on an exact match, so lowering SAMPLE_DIV below
  // the current count lets it run on to the natural 2^DIV_WIDTH rollover
  // instead of producing an early pulse. armed_q keeps the strobe low while
  // in reset and during the first cycle after release.
  always_comb begin
    div_hit = (div_q == SAMPLE_DIV);
    div_d   = div_hit ? '0 : div_q + 1'b1;
    armed_d = 1'b1;
  end

  assign SAMPLE_STB = armed_q & div_hit;

  // ---------------- per-channel command routing ----------------
  logic                 start_c [2];
  logic                 stop_c  [2];
  logic [31:0]          ftw_c   [2];
  logic [31:0]          ofs_c   [2];
  logic [CYC_WIDTH-1:0] cyc_c   [2];

`ifdef SINE_SEQ_SYNC_AB_EN
  logic sync_unused_cmd_b;
  assign sync_unused_cmd_b = START_B | STOP_B;
`endif

  always_comb begin
    start_c[0] = START_A;
    stop_c[0]  = STOP_A;
`ifdef SINE_SEQ_SYNC_AB_EN
    start_c[1] = START_A;
    stop_c[1]  = STOP_A;
`else
    start_c[1] = START_B;
    stop_c[1]  = STOP_B;
`endif
    ftw_c[0] = FTW_A;
    ftw_c[1] = FTW_B;
    ofs_c[0] = OFS_A;
    ofs_c[1] = OFS_B;
    cyc_c[0] = CYCLES_A;
    cyc_c[1] = CYCLES_B;
  end

  // ---------------- per-channel FSM + accumulator ----------------
  logic [1:0]           state_q [2], state_d [2];
  logic [31:0]          acc_q   [2], acc_d   [2];
  logic [31:0]          phase_q [2], phase_d [2];
  logic [CYC_WIDTH-1:0] rem_q   [2], rem_d   [2];
  logic                 burst_q [2], burst_d [2];
  logic [32:0]          sum_c   [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sum_c[i]   = {1'b0, acc_q[i]} + {1'b0, ftw_c[i]};
      state_d[i] = state_q[i];
      acc_d[i]   = acc_q[i];
      rem_d[i]   = rem_q[i];
      burst_d[i] = burst_q[i];
      // acc is held at zero outside RUN, so this default gives PHASE = OFS
      // while idle/done and tracks live OFS changes between strobes.
      phase_d[i] = acc_q[i] + ofs_c[i];

      if (stop_c[i]) begin
        state_d[i] = ST_IDLE;
        acc_d[i]   = '0;
        rem_d[i]   = '0;
        burst_d[i] = 1'b0;
        phase_d[i] = ofs_c[i];
      end else if (start_c[i]) begin
        state_d[i] = ST_RUN;
        acc_d[i]   = '0;
        rem_d[i]   = cyc_c[i];
        burst_d[i] = (cyc_c[i] != '0);
        phase_d[i] = ofs_c[i];
      end else if ((state_q[i] == ST_RUN) && SAMPLE_STB) begin
        // sum_c[i][32] is the carry out: one full waveform cycle finished.
        if (sum_c[i][32] && burst_q[i] && (rem_q[i] == CYC_ONE)) begin
          state_d[i] = ST_DONE;
          acc_d[i]   = '0;
          rem_d[i]   = '0;
          phase_d[i] = ofs_c[i];
        end else begin
          acc_d[i]   = sum_c[i][31:0];
          phase_d[i] = sum_c[i][31:0] + ofs_c[i];
          if (sum_c[i][32] && burst_q[i]) begin
            rem_d[i] = rem_q[i] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q   <= '0;
      armed_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        acc_q[i]   <= '0;
        phase_q[i] <= '0;
        rem_q[i]   <= '0;
        burst_q[i] <= 1'b0;
      end
    end else begin
      div_q   <= div_d;
      armed_q <= armed_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        acc_q[i]   <= acc_d[i];
        phase_q[i] <= phase_d[i];
        rem_q[i]   <= rem_d[i];
        burst_q[i] <= burst_d[i];
      end
    end
  end

  assign PHASE_A     = phase_q[0];
  assign PHASE_B     = phase_q[1];
  assign ACTIVE_A    = (state_q[0] == ST_RUN);
  assign ACTIVE_B    = (state_q[1] == ST_RUN);
  assign DONE_A      = (state_q[0] == ST_DONE);
  assign DONE_B      = (state_q[1] == ST_DONE);
  assign DBG_STATE_A = state_q[0];
  assign DBG_STATE_B = state_q[1];

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// tb_sine_phase_sequencer
// Directed scenarios followed by randomized traffic, all checked cycle by
// cycle against a behavioural model of the two channels kept in this file.
module tb_sine_phase_sequencer;

  localparam int          DIV_WIDTH = 16;
  localparam int          CYC_WIDTH = 16;
  localparam longint      TWO32     = 64'h1_0000_0000;
  localparam int          DIV_MOD   = 1 << DIV_WIDTH;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  logic [DIV_WIDTH-1:0] SAMPLE_DIV;
  logic                 START_A, START_B, STOP_A, STOP_B;
  logic [31:0]          FTW_A, FTW_B, OFS_A, OFS_B;
  logic [CYC_WIDTH-1:0] CYCLES_A, CYCLES_B;
  logic                 SAMPLE_STB;
  logic [31:0]          PHASE_A, PHASE_B;
  logic                 ACTIVE_A, ACTIVE_B, DONE_A, DONE_B;
  logic [1:0]           DBG_STATE_A, DBG_STATE_B;

  sine_phase_sequencer #(
    .DIV_WIDTH(DIV_WIDTH),
    .CYC_WIDTH(CYC_WIDTH)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SAMPLE_DIV(SAMPLE_DIV),
    .START_A(START_A), .START_B(START_B), .STOP_A(STOP_A), .STOP_B(STOP_B),
    .FTW_A(FTW_A), .FTW_B(FTW_B), .OFS_A(OFS_A), .OFS_B(OFS_B),
    .CYCLES_A(CYCLES_A), .CYCLES_B(CYCLES_B), .SAMPLE_STB(SAMPLE_STB),
    .PHASE_A(PHASE_A), .PHASE_B(PHASE_B), .ACTIVE_A(ACTIVE_A),
    .ACTIVE_B(ACTIVE_B), .DONE_A(DONE_A), .DONE_B(DONE_B),
    .DBG_STATE_A(DBG_STATE_A), .DBG_STATE_B(DBG_STATE_B)
  );

  // ---------------- scoreboard counters ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_div;
  bit          m_armed;
  bit          m_run   [2];
  bit          m_done  [2];
  bit          m_burst [2];
  int          m_left  [2];
  longint      m_acc   [2];
  logic [31:0] m_phase [2];

  task automatic model_reset();
    m_div   = 0;
    m_armed = 0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_done[i] = 0; m_burst[i] = 0; m_left[i] = 0;
      m_acc[i] = 0; m_phase[i] = '0;
    end
  endtask

  // One rising edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step(input bit stb);
    bit     st [2];
    bit     sp [2];
    longint ftw [2];
    longint ofs [2];
    int     cyc [2];
    longint s;
    st[0] = START_A; sp[0] = STOP_A;
`ifdef SINE_SEQ_SYNC_AB_EN
    st[1] = START_A; sp[1] = STOP_A;
`else
    st[1] = START_B; sp[1] = STOP_B;
`endif
    ftw[0] = longint'(FTW_A); ftw[1] = longint'(FTW_B);
    ofs[0] = longint'(OFS_A); ofs[1] = longint'(OFS_B);
    cyc[0] = int'(CYCLES_A);  cyc[1] = int'(CYCLES_B);

    if (m_div == int'(SAMPLE_DIV)) m_div = 0;
    else m_div = (m_div + 1) % DIV_MOD;
    m_armed = 1;

    for (int i = 0; i < 2; i++) begin
      if (sp[i]) begin
        m_run[i] = 0; m_done[i] = 0; m_acc[i] = 0;
      end else if (st[i]) begin
        m_run[i] = 1; m_done[i] = 0; m_acc[i] = 0;
        m_left[i] = cyc[i]; m_burst[i] = (cyc[i] != 0);
      end else if (m_run[i] && stb) begin
        s = m_acc[i] + ftw[i];
        m_acc[i] = s % TWO32;
        if (s >= TWO32 && m_burst[i]) m_left[i]--;
        if (m_burst[i] && m_left[i] == 0) begin
          m_run[i] = 0; m_done[i] = 1; m_acc[i] = 0;
        end
      end
      s = (m_acc[i] + ofs[i]) % TWO32;
      m_phase[i] = s[31:0];
    end
  endtask

  // ---------------- driver ----------------
  logic obs_stb;

  // Called at a falling edge with inputs already driven; returns at the
  // next falling edge with single-cycle commands cleared.
  task automatic tick();
    bit exp_stb;
    #1;
    exp_stb = m_armed && (m_div == int'(SAMPLE_DIV));
    obs_stb = SAMPLE_STB;
    chk("sample_stb", {31'b0, SAMPLE_STB}, {31'b0, exp_stb});
    @(posedge CLK);
    model_step(exp_stb);
    @(negedge CLK);
    chk("phase_a",  PHASE_A, m_phase[0]);
    chk("phase_b",  PHASE_B, m_phase[1]);
    chk("active_a", {31'b0, ACTIVE_A}, {31'b0, m_run[0]});
    chk("active_b", {31'b0, ACTIVE_B}, {31'b0, m_run[1]});
    chk("done_a",   {31'b0, DONE_A},   {31'b0, m_done[0]});
    chk("done_b",   {31'b0, DONE_B},   {31'b0, m_done[1]});
    START_A = 0; START_B = 0; STOP_A = 0; STOP_B = 0;
  endtask

  // Change the divider only when it cannot strand the count above the new value.
  task automatic set_div(input int v);
    while (m_div > v) tick();
    SAMPLE_DIV = v[DIV_WIDTH-1:0];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb"},     {31'b0, SAMPLE_STB}, 32'd0);
    chk({tag, "_phase_a"}, PHASE_A, 32'd0);
    chk({tag, "_phase_b"}, PHASE_B, 32'd0);
    chk({tag, "_flags"},   {28'b0, ACTIVE_A, ACTIVE_B, DONE_A, DONE_B}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET_N = 0; SAMPLE_DIV = 0;
    START_A = 0; START_B = 0; STOP_A = 0; STOP_B = 0;
    FTW_A = 0; FTW_B = 0; OFS_A = 0; OFS_B = 0; CYCLES_A = 0; CYCLES_B = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RESET_N = 1;

    // Divider period 4: strobes on cycles 3, 7, 11.
    SAMPLE_DIV = 3;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("div3_stb", {31'b0, obs_stb}, {31'b0, (i % 4) == 3});
    end
    set_div(0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("div0_stb", {31'b0, obs_stb}, 32'd1);
    end

    // Continuous run, quarter-turn steps.
    FTW_A = 32'h4000_0000; OFS_A = 0; CYCLES_A = 0;
    START_A = 1;
    tick();
    exp_q = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000};
    while (exp_q.size() > 0) begin
      tick();
      chk("cont_phase_a", PHASE_A, exp_q.pop_front());
      chk("cont_active_a", {31'b0, ACTIVE_A}, 32'd1);
    end

`ifndef SINE_SEQ_SYNC_AB_EN
    // Three-cycle burst on B at half-turn steps, strobe every 2 clocks.
    set_div(1);
    FTW_B = 32'h8000_0000; CYCLES_B = 3; OFS_B = 32'h1234_5678;
    START_B = 1;
    tick();
    repeat (14) tick();
    chk("burst_done_b",   {31'b0, DONE_B},   32'd1);
    chk("burst_active_b", {31'b0, ACTIVE_B}, 32'd0);
    chk("burst_phase_b",  PHASE_B, 32'h1234_5678);
    repeat (3) tick();
    chk("burst_done_hold_b", {31'b0, DONE_B}, 32'd1);
    STOP_B = 1;
    tick();
    chk("burst_stop_clr_b", {31'b0, DONE_B}, 32'd0);
`endif

    // Offset in IDLE, then a live FTW change mid-run.
    STOP_A = 1;
    tick();
    OFS_A = 32'h2000_0000;
    tick(); tick();
    chk("idle_ofs_a", PHASE_A, 32'h2000_0000);
    set_div(0);
    FTW_A = 32'h1000_0000; CYCLES_A = 0;
    START_A = 1;
    tick();
    tick();
    chk("ftw1_step1", PHASE_A, 32'h3000_0000);
    tick();
    chk("ftw1_step2", PHASE_A, 32'h4000_0000);
    FTW_A = 32'h2000_0000;
    tick();
    chk("ftw2_step", PHASE_A, 32'h6000_0000);

    // START and STOP together: STOP wins.
    START_A = 1; STOP_A = 1;
    tick();
    chk("start_stop_a", {31'b0, ACTIVE_A}, 32'd0);

`ifndef SINE_SEQ_SYNC_AB_EN
    // STOP on the final-wrap strobe of a one-cycle burst.
    FTW_B = 32'h8000_0000; CYCLES_B = 1;
    START_B = 1;
    tick();
    tick();
    STOP_B = 1;
    tick();
    chk("stop_final_done_b",   {31'b0, DONE_B},   32'd0);
    chk("stop_final_active_b", {31'b0, ACTIVE_B}, 32'd0);
`else
    // Linked channels: A commands drive both, B commands are ignored.
    FTW_B = 32'h0100_0000; CYCLES_B = 0;
    START_A = 1;
    tick();
    chk("sync_active_a", {31'b0, ACTIVE_A}, 32'd1);
    chk("sync_active_b", {31'b0, ACTIVE_B}, 32'd1);
    STOP_A = 1;
    tick();
    START_B = 1;
    tick();
    chk("sync_startb_a", {31'b0, ACTIVE_A}, 32'd0);
    chk("sync_startb_b", {31'b0, ACTIVE_B}, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) set_div($urandom_range(0, 3));
      START_A = ($urandom_range(0, 19) == 0);
      START_B = ($urandom_range(0, 19) == 0);
      STOP_A  = ($urandom_range(0, 39) == 0);
      STOP_B  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) FTW_A = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) FTW_B = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) OFS_A = $urandom;
      if ($urandom_range(0, 15) == 0) OFS_B = $urandom;
      CYCLES_A = CYC_WIDTH'($urandom_range(0, 3));
      CYCLES_B = CYC_WIDTH'($urandom_range(0, 3));
      tick();
    end

    // Async reset in the middle of a burst.
    set_div(1);
    FTW_A = 32'h0800_0000; CYCLES_A = 5; OFS_A = 32'h0000_1000;
    START_A = 1;
    tick();
    repeat (5) tick();
    #2 RESET_N = 0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge CLK);
    RESET_N = 1;
    repeat (6) tick();
    chk("post_rst_active_a", {31'b0, ACTIVE_A}, 32'd0);
    chk("post_rst_phase_a",  PHASE_A, 32'h0000_1000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
